nf_gpio: RTL
============

Name: nf_gpio

Overview:
- Memory-mapped GPIO peripheral on the nanoFOX data bus, directly downstream of the CPU load/store path.
- Produces the gpo/gpd pin controls and consumes gpi; these are the signals the top-level bench ties to its tristate gpio model.
- Adds input synchronisation, per-bit edge detection and a level interrupt request, so firmware can poll or wait on pin events.

Parameters:
- gpio_w, 8, number of GPIO bits (1..32)
- sync_st, 2, synchroniser depth on gpi (>=2)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- resetn  input  1  asynchronous active-low reset
- addr  input  32  byte address from bus decoder; only addr[4:2] decoded
- we  input  1  write strobe, one-cycle, sampled at rising clk
- wd  input  32  write data; bits above gpio_w-1 ignored
- rd  output  32  read data, combinational from addr; upper bits zero
- gpi  input  gpio_w  raw (asynchronous) pin inputs
- gpo  output  gpio_w  output values, registered
- gpd  output  gpio_w  direction, 1 = drive pin, registered
- irq  output  1  interrupt request, registered, level-high

Behaviour:
- Reset: gpo, gpd, IE, POL, IP, sync chain, prev, irq all 0 (all pins inputs); asserting resetn mid-operation clears everything immediately, no pending event survives.
- Register map (addr[4:2]):
  - 0 GPI: RO, last sync stage
  - 1 GPO: RW
  - 2 GPD: RW
  - 3 IE: RW, per-bit interrupt enable
  - 4 POL: RW, 0 = rising edge, 1 = falling edge
  - 5 IP: R/W1C pending
  - 6 GPO_SET: WO, gpo |= wd
  - 7 GPO_CLR: WO, gpo &= ~wd
  - Write-only registers read 0.
- Writes take effect at the rising clk where we=1; the new value is visible on rd and outputs from the next cycle.
- Reads have zero wait states: rd is a mux of current register state selected by addr.
- Synchroniser: gpi passes through sync_st flops; sync_out = last stage.
- prev = sync_out delayed by one cycle.
- Event[i] = POL[i] ? (prev[i] & ~sync_out[i]) : (sync_out[i] & ~prev[i]).
- IP[i] sets at the clk edge where Event[i] & IE[i]. Events on bits with IE[i]=0 are discarded, never latched.
- Write to IP: bits with wd[i]=1 clear. When a clear and a new event for the same bit coincide, set wins (IP[i]=1).
- Changing POL or IE does not alter existing IP bits.
- irq <= |(IP & IE), registered; clearing IE[i] drops that bit's contribution to irq one cycle later.
- Latency with sync_st=2: gpi change settled before edge N gives
  - GPI read reflects it after edge N+1
  - IP set at edge N+2
  - irq high after edge N+3
- Since prev resets to 0 and IE resets to 0, a pin held high through reset creates no pending interrupt.
- gpo/gpd are independent of gpi; loopback through the external tristate is visible on GPI after sync latency.

Test Plan:
- Reset defaults: hold resetn=0 with gpi=8'hFF, release, read all regs -> gpo=0, gpd=0, IE=0, IP=0, irq=0; GPI read = 32'h000000FF after 2 clocks.
- Output path: write GPD=8'h0F, GPO=8'hA5; then GPO_SET=8'h10, GPO_CLR=8'h05 -> gpd=8'h0F, gpo goes 8'hA5 -> 8'hB5 -> 8'hB0; reads of addr 6/7 return 0.
- Rising interrupt: IE=8'h01, POL=0, gpi[0] 0->1 before edge N -> IP=32'h1 after edge N+2, irq=1 after N+3; write IP=1 -> IP=0, irq=0 one cycle later.
- Falling/disabled: POL=8'h02, IE=8'h02, toggle gpi[1] 0->1->0 and gpi[2] 0->1 -> only IP[1] sets, exactly once, on the falling edge; IP[2]=0.
- Simultaneous clear and event: with IP[0]=1, issue W1C on IP[0] in the same cycle a new rising event on bit 0 is latched -> IP[0] stays 1 and irq stays 1.
- Reset mid-operation: IP=8'h03, irq=1, pulse resetn low asynchronously between edges -> irq, IP, gpo, gpd drop to 0 without waiting for clk; no IP bit is set after release.

Source files
------------

// File: rtl/nf_gpio.sv
// -----------------------------------------------------------------------------
// nf_gpio - memory-mapped GPIO peripheral for the nanoFOX data bus.
//
// Drives the pin controls (gpo value, gpd direction) and samples the raw pin
// inputs through a synchroniser. Each bit has an edge detector with selectable
// polarity, a sticky pending flag and an enable; the OR of enabled pending bits
// forms a registered level interrupt request.
//
// Ports:
//   clk     system clock, all state updates on the rising edge
//   resetn  asynchronous active-low reset
//   addr    byte address from the bus decoder, only addr[4:2] decoded
//   we      one-cycle write strobe
//   wd      write data, bits above gpio_w-1 ignored
//   rd      read data, combinational from addr, upper bits zero
//   gpi     raw asynchronous pin inputs
//   gpo     registered output values
//   gpd     registered direction, 1 = drive pin
//   irq     registered level-high interrupt request
//
// Register map (addr[4:2]):
//   0 GPI (RO)  1 GPO  2 GPD  3 IE  4 POL (0 rise, 1 fall)
//   5 IP (W1C)  6 GPO_SET (WO)  7 GPO_CLR (WO); write-only registers read 0
// -----------------------------------------------------------------------------
module nf_gpio #(
  parameter int gpio_w  = 8,
  parameter int sync_st = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       addr,
  input  logic              we,
  input  logic [31:0]       wd,
  output logic [31:0]       rd,
  input  logic [gpio_w-1:0] gpi,
  output logic [gpio_w-1:0] gpo,
  output logic [gpio_w-1:0] gpd,
  output logic              irq
);

  localparam logic [2:0] REG_GPI     = 3'd0;
  localparam logic [2:0] REG_GPO     = 3'd1;
  localparam logic [2:0] REG_GPD     = 3'd2;
  localparam logic [2:0] REG_IE      = 3'd3;
  localparam logic [2:0] REG_POL     = 3'd4;
  localparam logic [2:0] REG_IP      = 3'd5;
  localparam logic [2:0] REG_GPO_SET = 3'd6;
  localparam logic [2:0] REG_GPO_CLR = 3'd7;

  logic [2:0]        sel;
  logic [gpio_w-1:0] wd_g;
  logic [gpio_w-1:0] sync_q [sync_st];
  logic [gpio_w-1:0] sync_out;
  logic [gpio_w-1:0] prev;
  logic [gpio_w-1:0] ie;
  logic [gpio_w-1:0] pol;
  logic [gpio_w-1:0] ip;
  logic [gpio_w-1:0] ip_kept;
  logic [gpio_w-1:0] pin_event;
  logic [gpio_w-1:0] rd_sel;

  assign sel  = addr[4:2];
  assign wd_g = wd[gpio_w-1:0];

  // Address bits outside [4:2] and write data above gpio_w are don't-care.
  logic unused_bits;
  assign unused_bits = ^{addr[31:5], addr[1:0], wd};

  // Input synchroniser. gpi is asynchronous; only the last stage is used.
  // NOTE: this array is a flop chain, not a RAM, so every stage is reset; a
  // stale synchroniser value surviving reset would fake an edge afterwards.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < sync_st; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpi;
      for (int i = 1; i < sync_st; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_out = sync_q[sync_st-1];

  // Edge detector: prev is the synchronised pin one cycle ago. Because prev
  // resets to 0, a pin held high through reset looks like a rising edge
  // afterwards; IE is also 0 out of reset, so that edge is discarded.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) prev <= '0;
    else         prev <= sync_out;
  end

  assign pin_event = (pol & prev & ~sync_out) | (~pol & sync_out & ~prev);

  // W1C clears are applied first and new enabled events are ORed in after,
  // so an event coinciding with a clear of the same bit leaves it pending.
  assign ip_kept = (we && (sel == REG_IP)) ? (ip & ~wd_g) : ip;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, e.g. irq below sees ip from before this edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gpo <= '0;
      gpd <= '0;
      ie  <= '0;
      pol <= '0;
      ip  <= '0;
      irq <= 1'b0;
    end else begin
      ip  <= ip_kept | (pin_event & ie);
      irq <= |(ip & ie);
      if (we) begin
        case (sel)
          REG_GPO:     gpo <= wd_g;
          REG_GPD:     gpd <= wd_g;
          REG_IE:      ie  <= wd_g;
          REG_POL:     pol <= wd_g;
          REG_GPO_SET: gpo <= gpo | wd_g;
          REG_GPO_CLR: gpo <= gpo & ~wd_g;
          default:     ;
        endcase
      end
    end
  end

  // Zero-wait-state read mux.
  // NOTE: the default assignment up front keeps this purely combinational;
  // any path leaving rd_sel unassigned would infer a latch.
  always_comb begin
    rd_sel = '0;
    case (sel)
      REG_GPI: rd_sel = sync_out;
      REG_GPO: rd_sel = gpo;
      REG_GPD: rd_sel = gpd;
      REG_IE:  rd_sel = ie;
      REG_POL: rd_sel = pol;
      REG_IP:  rd_sel = ip;
      default: rd_sel = '0;
    endcase
  end

  assign rd = 32'(rd_sel);

endmodule
